// File: rtl/wf68k30_l_top_if.sv
// Processor bus bundle: address/data, strobes, terminations and static status lines.
// master = processor side, slave = memory/system side.
interface wf68k30_l_top_if;
    logic [31:0] ADR_OUT;
    logic [31:0] DATA_IN;
    logic [31:0] DATA_OUT;
    logic        DATA_EN;
    logic        ASn;
    logic        DSn;
    logic        DBENn;
    logic        RWn;
    logic [1:0]  SIZE;
    logic [2:0]  FC_OUT;
    logic [1:0]  DSACKn;
    logic        STERMn;
    logic        BERRn;
    logic        HALT_INn;
    logic        HALT_OUTn;
    logic        BUS_EN;
    logic        RESET_OUT;
    logic        IPENDn;
    logic        RMCn;
    logic        ECSn;
    logic        OCSn;
    logic        STATUSn;
    logic        REFILLn;
    logic        BGn;
    logic        AVECn;
    logic [2:0]  IPLn;
    logic        BRn;
    logic        BGACKn;

    modport master (
        output ADR_OUT, DATA_OUT, DATA_EN, ASn, DSn, DBENn, RWn, SIZE, FC_OUT,
               HALT_OUTn, BUS_EN, RESET_OUT, IPENDn, RMCn, ECSn, OCSn, STATUSn, REFILLn, BGn,
        input  DATA_IN, DSACKn, STERMn, BERRn, HALT_INn, AVECn, IPLn, BRn, BGACKn
    );

    modport slave (
        input  ADR_OUT, DATA_OUT, DATA_EN, ASn, DSn, DBENn, RWn, SIZE, FC_OUT,
               HALT_OUTn, BUS_EN, RESET_OUT, IPENDn, RMCn, ECSn, OCSn, STATUSn, REFILLn, BGn,
        output DATA_IN, DSACKn, STERMn, BERRn, HALT_INn, AVECn, IPLn, BRn, BGACKn
    );
endinterface

// File: rtl/wf68k30_l_top.sv
// Minimal 68030-style core: reset vector load, NOP / BRA.S / MOVE.L #imm,abs.L, halt on anything else.
// Each access is IDLE -> ACTIVE -> END; decode of a fetched opcode happens during the END cycle.
module wf68k30_l_top #(
    parameter bit NO_PIPELINE = 1'b0,
    parameter bit NO_LOOP     = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RESET_IN,
    wf68k30_l_top_if.master        bus
);

    typedef enum logic [2:0] {RST_SSP, RST_PC, FETCH, DECODE, EXT, WRITE, HALT} state_t;
    typedef enum logic [1:0] {B_IDLE, B_ACTIVE, B_END} bus_t;

    state_t      st_q, st_d;
    bus_t        bus_q;
    logic [31:0] pc_q, pc_d, ssp_q, imm_q, ea_q, adr_q, dout_q, acc_adr;
    logic [15:0] op_q, word;
    logic [1:0]  cnt_q;
    logic [2:0]  fc_q, acc_fc;
    logic        strb_q, rw_q, den_q, halt_q, acc_rw, term;

    assign word = pc_q[1] ? bus.DATA_IN[15:0] : bus.DATA_IN[31:16];
    assign term = (bus.DSACKn != 2'b11) || !bus.STERMn;

    // Resolves a pending decode and picks the next access while the bus is between cycles.
    always_comb begin
        st_d = st_q;
        pc_d = pc_q;
        if (st_q == DECODE) begin
            if (op_q == 16'h4E71) begin
                st_d = FETCH;
            end else if (op_q[15:8] == 8'h60 && op_q[7:0] != 8'h00 && op_q[7:0] != 8'hFF) begin
                st_d = FETCH;
                pc_d = pc_q + {{24{op_q[7]}}, op_q[7:0]};
            end else if (op_q == 16'h23FC) begin
                st_d = EXT;
            end else begin
                st_d = HALT;
            end
        end
        if (st_d == FETCH && pc_d[0]) begin
            st_d = HALT;
        end
        case (st_d)
            RST_SSP: acc_adr = 32'h0000_0000;
            RST_PC:  acc_adr = 32'h0000_0004;
            WRITE:   acc_adr = ea_q;
            default: acc_adr = {pc_d[31:2], 2'b00};
        endcase
        acc_fc = (st_d == FETCH || st_d == EXT) ? 3'b110 : 3'b101;
        acc_rw = (st_d != WRITE);
    end

    always_ff @(posedge CLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            st_q   <= RST_SSP;
            bus_q  <= B_IDLE;
            pc_q   <= '0;
            ssp_q  <= '0;
            imm_q  <= '0;
            ea_q   <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            adr_q  <= '0;
            dout_q <= '0;
            fc_q   <= 3'b101;
            strb_q <= 1'b1;
            rw_q   <= 1'b1;
            den_q  <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            case (bus_q)
                B_ACTIVE: begin
                    if (!bus.BERRn) begin
                        bus_q  <= B_IDLE;
                        strb_q <= 1'b1;
                        den_q  <= 1'b0;
                        rw_q   <= 1'b1;
                        st_q   <= HALT;
                        halt_q <= 1'b1;
                    end else if (term) begin
                        bus_q  <= B_END;
                        strb_q <= 1'b1;
                        den_q  <= 1'b0;
                        rw_q   <= 1'b1;
                        case (st_q)
                            RST_SSP: begin
                                ssp_q <= bus.DATA_IN;
                                st_q  <= RST_PC;
                            end
                            RST_PC: begin
                                pc_q <= bus.DATA_IN;
                                st_q <= FETCH;
                            end
                            FETCH: begin
                                op_q <= word;
                                pc_q <= pc_q + 32'd2;
                                st_q <= DECODE;
                            end
                            EXT: begin
                                pc_q  <= pc_q + 32'd2;
                                cnt_q <= cnt_q + 2'd1;
                                case (cnt_q)
                                    2'd0: imm_q[31:16] <= word;
                                    2'd1: imm_q[15:0]  <= word;
                                    2'd2: ea_q[31:16]  <= word;
                                    default: begin
                                        ea_q[15:0] <= word;
                                        st_q       <= WRITE;
                                    end
                                endcase
                            end
                            WRITE:   st_q <= FETCH;
                            default: st_q <= HALT;
                        endcase
                    end
                end
                default: begin
                    st_q <= st_d;
                    pc_q <= pc_d;
                    if (st_d == HALT) begin
                        halt_q <= 1'b1;
                        bus_q  <= B_IDLE;
                    end else if (!bus.HALT_INn) begin
                        bus_q <= B_IDLE;
                    end else begin
                        bus_q  <= B_ACTIVE;
                        strb_q <= 1'b0;
                        adr_q  <= acc_adr;
                        fc_q   <= acc_fc;
                        rw_q   <= acc_rw;
                        den_q  <= !acc_rw;
                        if (!acc_rw) begin
                            dout_q <= imm_q;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ADR_OUT   = adr_q;
    assign bus.DATA_OUT  = dout_q;
    assign bus.DATA_EN   = den_q;
    assign bus.ASn       = strb_q;
    assign bus.DSn       = strb_q;
    assign bus.DBENn     = strb_q;
    assign bus.RWn       = rw_q;
    assign bus.SIZE      = 2'b00;
    assign bus.FC_OUT    = fc_q;
    assign bus.HALT_OUTn = ~halt_q;
    assign bus.BUS_EN    = ~RESET_IN;
    assign bus.RESET_OUT = 1'b0;
    assign bus.IPENDn    = 1'b1;
    assign bus.RMCn      = 1'b1;
    assign bus.ECSn      = 1'b1;
    assign bus.OCSn      = 1'b1;
    assign bus.STATUSn   = 1'b1;
    assign bus.REFILLn   = 1'b1;
    assign bus.BGn       = 1'b1;

    // SSP is loaded but never consumed by this instruction subset.
    logic unused_ok;
    assign unused_ok = ^{NO_PIPELINE, NO_LOOP, ssp_q, bus.AVECn, bus.IPLn, bus.BRn, bus.BGACKn};

endmodule

// File: tb/tb_wf68k30_l_top.sv
// Bench: table of small programs plus random programs/bus timing, each trace compared with an
// instruction-level model; hand sequences for reset, bus error and mid-cycle reset.
`timescale 1ns/1ps
module tb_wf68k30_l_top;

    typedef struct packed {
        logic        rw;
        logic [31:0] adr;
        logic [2:0]  fc;
        logic [31:0] dat;
        logic        den;
    } txn_t;

    typedef struct packed {
        logic [7:0][15:0] w;
        logic             sterm;
        logic             exp_halt;
        logic [7:0]       exp_nwr;
        logic [31:0]      exp_wadr;
        logic [31:0]      exp_wdat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wf68k30_l_top_if bif ();
    wf68k30_l_top #(.NO_PIPELINE(1'b0), .NO_LOOP(1'b0)) dut (.CLK(clk), .RESET_IN(rst), .bus(bif));

    logic [31:0] mem [256];
    txn_t        got_q[$];
    txn_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          rand_wait = 0, rand_halt = 0, use_sterm = 0, berr_arm = 0, hold_term = 0, gap_en = 0;
    logic [31:0] berr_adr = '0;
    int          gap_err = 0, strobe_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_txn(input string tag, input int i, input txn_t g, input txn_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s txn%0d: got rw=%b adr=%h fc=%b dat=%h en=%b expected rw=%b adr=%h fc=%b dat=%h en=%b",
                     tag, i, g.rw, g.adr, g.fc, g.dat, g.den, e.rw, e.adr, e.fc, e.dat, e.den);
        end
    endtask

    // Memory/system side: random wait states, termination type, optional bus error.
    initial begin
        int waited = 0;
        int hi_run = 0;
        bit seen_act = 0;
        bif.DATA_IN = '0; bif.DSACKn = 2'b11; bif.STERMn = 1'b1; bif.BERRn = 1'b1; bif.HALT_INn = 1'b1;
        bif.AVECn = 1'b1; bif.IPLn = 3'b111; bif.BRn = 1'b1; bif.BGACKn = 1'b1;
        forever begin
            @(negedge clk);
            bif.DSACKn = 2'b11; bif.STERMn = 1'b1; bif.BERRn = 1'b1;
            bif.HALT_INn = rand_halt ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rst) begin
                hi_run = 0; seen_act = 0; waited = 0;
            end else begin
                if (bif.DSn !== bif.ASn || bif.DBENn !== bif.ASn || bif.SIZE !== 2'b00 ||
                    bif.DATA_EN !== (!bif.ASn && !bif.RWn))
                    strobe_err++;
                if (bif.ASn) hi_run++;
                else begin
                    if (gap_en && seen_act && hi_run > 1) gap_err++;
                    hi_run = 0; seen_act = 1;
                    if (berr_arm && bif.ADR_OUT == berr_adr) bif.BERRn = 1'b0;
                    else if (!hold_term && (!rand_wait || waited >= 3 || $urandom_range(0, 1) == 1)) begin
                        if (use_sterm || $urandom_range(0, 1) == 1) bif.STERMn = 1'b0;
                        else bif.DSACKn = 2'($urandom_range(0, 2));
                        bif.DATA_IN = mem[bif.ADR_OUT[9:2]];
                        got_q.push_back('{rw: bif.RWn, adr: bif.ADR_OUT, fc: bif.FC_OUT,
                                          dat: bif.RWn ? 32'h0 : bif.DATA_OUT, den: bif.DATA_EN});
                        waited = 0;
                    end else waited++;
                end
            end
        end
    end

    task automatic put_word(input logic [31:0] a, input logic [15:0] w);
        if (a[1]) mem[a[9:2]][15:0] = w;
        else      mem[a[9:2]][31:16] = w;
    endtask

    task automatic init_mem(input logic [31:0] ssp);
        for (int i = 0; i < 256; i++) mem[i] = 32'h4AFC_4AFC;
        mem[0] = ssp;
        mem[1] = 32'h0000_0008;
    endtask

    // Instruction-level reference: emits the bus transactions a program must produce.
    task automatic mfetch(inout logic [31:0] pc, output logic [15:0] w);
        logic [31:0] l;
        l = mem[pc[9:2]];
        exp_q.push_back('{rw: 1'b1, adr: {pc[31:2], 2'b00}, fc: 3'b110, dat: 32'h0, den: 1'b0});
        w = pc[1] ? l[15:0] : l[31:16];
        pc = pc + 32'd2;
    endtask

    task automatic model_run(input int cap, output bit halted);
        logic [31:0] pc, op_adr;
        logic [15:0] w, w1, w2, w3, w4;
        int disp;
        exp_q.delete();
        halted = 0;
        exp_q.push_back('{rw: 1'b1, adr: 32'h0, fc: 3'b101, dat: 32'h0, den: 1'b0});
        exp_q.push_back('{rw: 1'b1, adr: 32'h4, fc: 3'b101, dat: 32'h0, den: 1'b0});
        pc = mem[1];
        while (!halted && exp_q.size() < cap) begin
            if (pc[0]) halted = 1;
            else begin
                op_adr = pc;
                mfetch(pc, w);
                if (w == 16'h4E71) begin
                end else if (w[15:8] == 8'h60 && w[7:0] != 8'h00 && w[7:0] != 8'hFF) begin
                    disp = int'($signed(w[7:0]));
                    pc = op_adr + 32'd2 + 32'(disp);
                end else if (w == 16'h23FC) begin
                    mfetch(pc, w1); mfetch(pc, w2); mfetch(pc, w3); mfetch(pc, w4);
                    exp_q.push_back('{rw: 1'b0, adr: {w3, w4}, fc: 3'b101, dat: {w1, w2}, den: 1'b1});
                end else halted = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got_q.delete();
        rst = 1'b0;
    endtask

    task automatic run_prog(input int maxn, input string tag);
        bit mh;
        int cyc, n, lows;
        model_run(maxn + 8, mh);
        do_reset();
        cyc = 0;
        while (got_q.size() < maxn && bif.HALT_OUTn && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_timeout"}, 32'(cyc < 3000), 32'd1);
        if (!bif.HALT_OUTn) begin
            lows = 0;
            repeat (6) begin
                @(negedge clk);
                if (!bif.ASn) lows++;
            end
            chk({tag, "_quiet_after_halt"}, 32'(lows), 32'd0);
        end
        if (mh && exp_q.size() <= maxn) begin
            chk({tag, "_halt"}, 32'(bif.HALT_OUTn), 32'd0);
            chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        end else if (!mh) begin
            chk({tag, "_nohalt"}, 32'(bif.HALT_OUTn), 32'd1);
        end
        n = maxn;
        if (exp_q.size() < n) n = exp_q.size();
        if (got_q.size() < n) n = got_q.size();
        for (int i = 0; i < n; i++) chk_txn(tag, i, got_q[i], exp_q[i]);
    endtask

    initial begin
        vec_t vt [9];
        int   cyc, nwr;
        logic [31:0] wadr, wdat, a;
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt [9];
        int          cyc, nwr, sel, dd, cnt;
        logic [31:0] wadr, wdat, a;

        vt[0] = '{w: {16'h23FC, 16'h1234, 16'h5678, 16'h0000, 16'h0100, 16'h60FE, 16'h4AFC, 16'h4AFC},
                  sterm: 0, exp_halt: 0, exp_nwr: 1, exp_wadr: 32'h0000_0100, exp_wdat: 32'h1234_5678};
        vt[1] = '{w: {16'h4E71, 16'h60FE, 16'h4AFC, 16'h4AFC, 16'h4AFC, 16'h4AFC, 16'h4AFC, 16'h4AFC},
                  sterm: 0, exp_halt: 0, exp_nwr: 0, exp_wadr: 32'h0, exp_wdat: 32'h0};
        vt[2] = '{w: {16'h4AFC, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71},
                  sterm: 0, exp_halt: 1, exp_nwr: 0, exp_wadr: 32'h0, exp_wdat: 32'h0};
        vt[3] = '{w: {16'h6002, 16'h4AFC, 16'h23FC, 16'hAAAA, 16'h5555, 16'h0000, 16'h0200, 16'h60FE},
                  sterm: 0, exp_halt: 0, exp_nwr: 1, exp_wadr: 32'h0000_0200, exp_wdat: 32'hAAAA_5555};
        vt[4] = '{w: {16'h6001, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71, 16'h60FE},
                  sterm: 0, exp_halt: 1, exp_nwr: 0, exp_wadr: 32'h0, exp_wdat: 32'h0};
        vt[5] = '{w: {16'h60FF, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71, 16'h60FE},
                  sterm: 0, exp_halt: 1, exp_nwr: 0, exp_wadr: 32'h0, exp_wdat: 32'h0};
        vt[6] = '{w: {16'h4E71, 16'h4E71, 16'h4AFC, 16'h60FE, 16'h4E71, 16'h4E71, 16'h4E71, 16'h4E71},
                  sterm: 0, exp_halt: 1, exp_nwr: 0, exp_wadr: 32'h0, exp_wdat: 32'h0};
        vt[7] = '{w: {16'h23FC, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFC, 16'h60FE, 16'h4AFC, 16'h4AFC},
                  sterm: 0, exp_halt: 0, exp_nwr: 1, exp_wadr: 32'hFFFF_FFFC, exp_wdat: 32'hFFFF_0000};
        vt[8] = '{w: {16'h23FC, 16'h1234, 16'h5678, 16'h0000, 16'h0100, 16'h60FE, 16'h4AFC, 16'h4AFC},
                  sterm: 1, exp_halt: 0, exp_nwr: 1, exp_wadr: 32'h0000_0100, exp_wdat: 32'h1234_5678};

        rst = 1'b1;
        init_mem(32'h0000_1000);
        repeat (2) @(negedge clk);
        chk("rst_strobes", 32'({bif.ASn, bif.DSn, bif.DBENn, bif.RWn, bif.DATA_EN, bif.HALT_OUTn}), 32'b111101);
        chk("rst_adr", bif.ADR_OUT, 32'h0);
        chk("rst_dout", bif.DATA_OUT, 32'h0);
        chk("rst_fc", 32'(bif.FC_OUT), 32'h5);
        chk("rst_misc", 32'({bif.BUS_EN, bif.RESET_OUT, bif.SIZE}), 32'h0);
        chk("rst_static", 32'({bif.IPENDn, bif.RMCn, bif.ECSn, bif.OCSn, bif.STATUSn, bif.REFILLn, bif.BGn}), 32'h7F);
        chk("rst_pc_ssp", dut.pc_q | dut.ssp_q, 32'h0);

        // Table vectors: hand-derived expectations plus full trace against the model.
        gap_en = 1;
        for (int v = 0; v < 9; v++) begin
            init_mem(32'h0000_1000);
            for (int k = 0; k < 8; k++) put_word(32'h8 + 32'(2 * k), vt[v].w[7 - k]);
            use_sterm = vt[v].sterm;
            run_prog(16, $sformatf("vec%0d", v));
            nwr = 0; wadr = '0; wdat = '0;
            for (int i = 0; i < got_q.size() && i < 16; i++)
                if (!got_q[i].rw) begin
                    if (nwr == 0) begin wadr = got_q[i].adr; wdat = got_q[i].dat; end
                    nwr++;
                end
            chk($sformatf("vec%0d_halted", v), 32'(!bif.HALT_OUTn), 32'(vt[v].exp_halt));
            chk($sformatf("vec%0d_nwr", v), 32'(nwr), 32'(vt[v].exp_nwr));
            chk($sformatf("vec%0d_wadr", v), wadr, vt[v].exp_wadr);
            chk($sformatf("vec%0d_wdat", v), wdat, vt[v].exp_wdat);
            if (v == 0) chk("ssp_loaded", dut.ssp_q, 32'h0000_1000);
        end
        use_sterm = 0;
        gap_en = 0;
        chk("gap_one_cycle", 32'(gap_err), 32'd0);

        // Bus error on the second reset-vector read.
        init_mem(32'h0000_1000);
        put_word(32'h8, 16'h4E71); put_word(32'hA, 16'h60FE);
        berr_arm = 1; berr_adr = 32'h4;
        do_reset();
        cyc = 0;
        while (bif.HALT_OUTn && cyc < 50) begin @(negedge clk); cyc++; end
        chk("berr_halt", 32'(bif.HALT_OUTn), 32'd0);
        chk("berr_only_first_read", 32'(got_q.size()), 32'd1);
        repeat (4) @(negedge clk);
        chk("berr_as_idle", 32'(bif.ASn), 32'd1);
        berr_arm = 0;

        // Reset pulse during a stretched cycle.
        hold_term = 1;
        do_reset();
        cyc = 0;
        while (bif.ASn && cyc < 10) begin @(negedge clk); cyc++; end
        chk("first_active_le2", 32'(cyc >= 1 && cyc <= 2), 32'd1);
        chk("first_active_adr", bif.ADR_OUT, 32'h0);
        chk("first_active_fc_rw", 32'({bif.FC_OUT, bif.RWn}), 32'b1011);
        repeat (2) @(negedge clk);
        chk("stretched_as", 32'(bif.ASn), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_release", 32'({bif.ASn, bif.DSn, bif.DBENn}), 32'b111);
        hold_term = 0;
        repeat (2) @(negedge clk);
        got_q.delete();
        rst = 1'b0;
        cyc = 0;
        while (got_q.size() < 2 && cyc < 50) begin @(negedge clk); cyc++; end
        chk("restart_count", 32'(got_q.size() >= 2), 32'd1);
        if (got_q.size() >= 2) begin
            chk("restart_adr0", got_q[0].adr, 32'h0);
            chk("restart_adr1", got_q[1].adr, 32'h4);
        end

        // Random programs with random wait states, terminations and HALT_INn stalls.
        rand_wait = 1; rand_halt = 1;
        for (int r = 0; r < 8; r++) begin
            init_mem($urandom);
            a = 32'h8;
            cnt = $urandom_range(1, 6);
            for (int k = 0; k < cnt; k++) begin
                sel = $urandom_range(0, 3);
                if (sel == 1) begin
                    put_word(a, 16'h23FC); put_word(a + 2, 16'($urandom)); put_word(a + 4, 16'($urandom));
                    put_word(a + 6, 16'($urandom)); put_word(a + 8, 16'($urandom));
                    a = a + 32'd10;
                end else if (sel == 2) begin
                    dd = 2 * $urandom_range(1, 3);
                    put_word(a, 16'h6000 | 16'(dd));
                    a = a + 32'd2 + 32'(dd);
                end else begin
                    put_word(a, 16'h4E71);
                    a = a + 32'd2;
                end
            end
            case ($urandom_range(0, 3))
                0: put_word(a, 16'h60FE);
                1: put_word(a, 16'h4AFC);
                2: put_word(a, 16'h6003);
                default: put_word(a, 16'h6000);
            endcase
            run_prog(24, $sformatf("rnd%0d", r));
        end
        rand_wait = 0; rand_halt = 0;

        chk("strobe_consistency", 32'(strobe_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wf68k30_l_top.md
WF68K30_L_TOP -- requirements
Module: wf68k30_l_top

Interface
REQ-001 Parameter NO_PIPELINE, default 1'b0, accepted for compatibility; no functional effect.
REQ-002 Parameter NO_LOOP, default 1'b0, accepted for compatibility; no functional effect.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RESET_IN  in  1  asynchronous, active-high reset.
REQ-005 ADR_OUT  out  32  bus address.
REQ-006 DATA_IN  in  32  read data, byte 0 in bits [31:24].
REQ-007 DATA_OUT  out  32  write data; DATA_EN out 1 high while DATA_OUT is driven (write cycle).
REQ-008 ASn, DSn, DBENn  out  1 each  address strobe, data strobe, data buffer enable; low during a bus cycle.
REQ-009 RWn  out  1  1 = read, 0 = write; SIZE out 2 is always 00 (long).
REQ-010 FC_OUT  out  3  function code: 101 vector/data, 110 program fetch.
REQ-011 DSACKn  in  2  asynchronous cycle termination; STERMn in 1 synchronous termination (low).
REQ-012 BERRn  in  1  bus error (low); HALT_INn in 1 stalls new cycles (low); HALT_OUTn out 1 low when halted.
REQ-013 BUS_EN out 1 = 1 outside reset; RESET_OUT out 1 = 0; IPENDn, RMCn, ECSn, OCSn, STATUSn, REFILLn, BGn out 1 = 1 constantly.
REQ-014 AVECn, IPLn[2:0], BRn, BGACKn inputs are ignored.

Function
REQ-015 States: RST_SSP, RST_PC, FETCH, DECODE, EXT, WRITE, HALT; each bus access uses sub-states IDLE -> ACTIVE -> END.
REQ-016 IDLE: strobes high; next cycle starts on the next edge unless HALT_INn = 0, in which case it waits.
REQ-017 ACTIVE: ADR_OUT, RWn, FC_OUT stable; ASn = DSn = DBENn = 0; write cycles drive DATA_OUT with DATA_EN = 1.
REQ-018 A cycle terminates on the first rising edge where DSACKn != 11 or STERMn = 0. Read data is latched at that edge. All port sizes are treated as 32-bit.
REQ-019 END: strobes and DATA_EN return high for exactly one cycle before the next ACTIVE, so consecutive cycles have a one-cycle gap.
REQ-020 BERRn = 0 sampled in ACTIVE aborts the cycle and enters HALT.
REQ-021 After reset, read long at 0x00000000 into SSP (A7), then long at 0x00000004 into PC; both with FC = 101.
REQ-022 Instruction words are fetched with a long read at {PC[31:2],2'b00} and FC = 110. The word is DATA_IN[31:16] if PC[1] = 0, else DATA_IN[15:0]. PC += 2 per word; wraps modulo 2^32. There is no prefetch buffer.
REQ-023 0x4E71 (NOP): no effect.
REQ-024 0x60dd (BRA.S, dd != 00/FF): PC = address of opcode + 2 + sign-extended dd.
REQ-025 0x60FE is a valid self-loop.
REQ-026 0x23FC (MOVE.L #imm32,abs.L): fetch 2 immediate words, then 2 address words, then perform one write cycle with ADR_OUT = address, DATA_OUT = imm, FC = 101, SIZE = 00.
REQ-027 Any other opcode, or an odd PC, enters HALT. HALT: HALT_OUTn = 0, no further bus cycles until reset.

Reset
REQ-028 While RESET_IN = 1: ASn = DSn = DBENn = 1, RWn = 1, DATA_EN = 0, HALT_OUTn = 1, ADR_OUT = 0, DATA_OUT = 0, FC_OUT = 101, PC = 0, SSP = 0.
REQ-029 Reset asserted mid-cycle releases strobes immediately (asynchronously).
REQ-030 After release, the first ACTIVE (address 0x0) occurs within 2 clocks.

Verification
REQ-031 Memory[0] = 0x00001000, [4] = 0x00000008, release reset -> read 0x0 then 0x4 (FC 101), then fetch at 0x8 (FC 110); SSP = 0x1000.
REQ-032 At 0x8: 23FC 1234 5678 0000 0100 -> long reads at 0x8, 0x8, 0xC, 0xC, 0x10, then write ADR_OUT = 0x100, DATA_OUT = 0x12345678, RWn = 0, DATA_EN = 1.
REQ-033 At 0x8: 4E71 60FE -> repeated fetches at 0x8 forever; no writes; HALT_OUTn stays 1.
REQ-034 At 0x8: 4AFC -> HALT_OUTn = 0 after decode; ASn stays 1 thereafter.
REQ-035 BERRn = 0 during read at 0x4 -> cycle aborted, HALT_OUTn = 0; STERMn = 0 instead of DSACKn -> identical data to REQ-032.
REQ-036 RESET_IN pulsed while ASn = 0 -> ASn = 1 before the next edge; sequence restarts at 0x0.
